// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: FSM states, NOP word, default PC width.
package fetch_pkg;

  localparam int          PC_W_DEF = 9;
  localparam logic [31:0] NOP      = 32'h0;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_skid.sv
// One-entry skid buffer that parks the instruction returning from memory while fetch is stalled.
module fetch_skid
  import fetch_pkg::*;
#(
  parameter int PC_W = PC_W_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            clear,
  input  logic [31:0]     load_data,
  input  logic [PC_W-1:0] load_pc,
  output logic            full,
  output logic [31:0]     data,
  output logic [PC_W-1:0] pc
);

  logic            full_q, full_d;
  logic [31:0]     data_q, data_d;
  logic [PC_W-1:0] pc_q, pc_d;

  // Clear wins over load so a redirect can never leave a stale entry behind.
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    pc_d   = pc_q;
    if (clear) begin
      full_d = 1'b0;
    end else if (load) begin
      full_d = 1'b1;
      data_d = load_data;
      pc_d   = load_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      full_q <= 1'b0;
    end else begin
      full_q <= full_d;
    end
    data_q <= data_d;
    pc_q   <= pc_d;
  end

  assign full = full_q;
  assign data = data_q;
  assign pc   = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Single-issue instruction fetch stage feeding the IF/ID register from a 1-cycle synchronous memory.
// Optional performance counters are enabled by defining FETCH_PERF_CNT_EN.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              PC_W     = PC_W_DEF,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect_en,
  input  logic [PC_W-1:0] redirect_pc,
  output logic [PC_W-1:0] imem_addr,
  output logic            imem_en,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     id_inst,
  output logic [PC_W-1:0] id_pc,
  output logic            id_valid,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_stall
);

  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            infl_q, infl_d;
  logic [PC_W-1:0] infl_pc_q, infl_pc_d;
  logic [31:0]     id_inst_q, id_inst_d;
  logic [PC_W-1:0] id_pc_q, id_pc_d;
  logic            id_valid_q, id_valid_d;

  logic            skid_load, skid_clear, skid_full;
  logic [31:0]     skid_data;
  logic [PC_W-1:0] skid_pc;

  fetch_skid #(.PC_W(PC_W)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .load      (skid_load),
    .clear     (skid_clear),
    .load_data (imem_rdata),
    .load_pc   (infl_pc_q),
    .full      (skid_full),
    .data      (skid_data),
    .pc        (skid_pc)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    infl_d     = infl_q;
    infl_pc_d  = infl_pc_q;
    id_inst_d  = id_inst_q;
    id_pc_d    = id_pc_q;
    id_valid_d = id_valid_q;
    imem_addr  = pc_q;
    imem_en    = 1'b0;
    skid_load  = 1'b0;
    skid_clear = 1'b0;

    if (rst) begin
      if (redirect_en) begin
        imem_addr  = redirect_pc;
        imem_en    = 1'b1;
        pc_d       = redirect_pc + 1'b1;
        infl_d     = 1'b1;
        infl_pc_d  = redirect_pc;
        skid_clear = 1'b1;
        id_inst_d  = NOP;
        id_pc_d    = '0;
        id_valid_d = 1'b0;
        state_d    = RUN;
      end else begin
        unique case (state_q)
          BOOT: begin
            imem_en   = 1'b1;
            pc_d      = pc_q + 1'b1;
            infl_d    = 1'b1;
            infl_pc_d = pc_q;
            state_d   = RUN;
          end
          RUN: begin
            if (stall) begin
              // The word already requested still arrives this cycle; park it.
              skid_load = infl_q;
              infl_d    = 1'b0;
              state_d   = HOLD;
            end else begin
              id_inst_d  = imem_rdata;
              id_pc_d    = infl_pc_q;
              id_valid_d = infl_q;
              imem_en    = 1'b1;
              pc_d       = pc_q + 1'b1;
              infl_d     = 1'b1;
              infl_pc_d  = pc_q;
            end
          end
          HOLD: begin
            if (!stall) begin
              if (skid_full) begin
                id_inst_d  = skid_data;
                id_pc_d    = skid_pc;
                id_valid_d = 1'b1;
              end else begin
                id_inst_d  = imem_rdata;
                id_pc_d    = infl_pc_q;
                id_valid_d = infl_q;
              end
              skid_clear = 1'b1;
              imem_en    = 1'b1;
              pc_d       = pc_q + 1'b1;
              infl_d     = 1'b1;
              infl_pc_d  = pc_q;
              state_d    = RUN;
            end
          end
          default: state_d = BOOT;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      infl_q     <= 1'b0;
      id_inst_q  <= NOP;
      id_pc_q    <= '0;
      id_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      infl_q     <= infl_d;
      id_inst_q  <= id_inst_d;
      id_pc_q    <= id_pc_d;
      id_valid_q <= id_valid_d;
    end
    infl_pc_q <= infl_pc_d;
  end

  assign id_inst  = id_inst_q;
  assign id_pc    = id_pc_q;
  assign id_valid = id_valid_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_stall_q, perf_stall_d;
  logic        fetch_evt;

  // Mirrors the IF/ID load conditions above that produce a valid instruction.
  assign fetch_evt = !redirect_en && !stall &&
                     (((state_q == RUN) && infl_q) ||
                      ((state_q == HOLD) && (skid_full || infl_q)));

  always_comb begin
    perf_fetched_d = perf_fetched_q + {31'b0, fetch_evt};
    perf_stall_d   = perf_stall_q + {31'b0, stall};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_fetched_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_stall_q   <= perf_stall_d;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_stall   = perf_stall_q;
`else
  assign perf_fetched = '0;
  assign perf_stall   = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, streaming, stall/skid, redirect, PC wrap and counters.
module tb_fetch_unit;

  localparam int PC_W = 9;

  logic            clk = 1'b0;
  logic            rst;
  logic            stall;
  logic            redirect_en;
  logic [PC_W-1:0] redirect_pc;
  logic [PC_W-1:0] imem_addr;
  logic            imem_en;
  logic [31:0]     imem_rdata = 32'h0;
  logic [31:0]     id_inst;
  logic [PC_W-1:0] id_pc;
  logic            id_valid;
  logic [31:0]     perf_fetched;
  logic [31:0]     perf_stall;

  int n_cmp = 0;
  int n_bad = 0;

  fetch_unit #(.PC_W(PC_W), .RESET_PC(9'd0)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .redirect_en  (redirect_en),
    .redirect_pc  (redirect_pc),
    .imem_addr    (imem_addr),
    .imem_en      (imem_en),
    .imem_rdata   (imem_rdata),
    .id_inst      (id_inst),
    .id_pc        (id_pc),
    .id_valid     (id_valid),
    .perf_fetched (perf_fetched),
    .perf_stall   (perf_stall)
  );

  always #5 clk = ~clk;

  // mem[k] = k + 0x100, one-cycle read latency
  always @(posedge clk) begin
    if (imem_en) imem_rdata <= {23'h0, imem_addr} + 32'h100;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_id(input string tag, input logic [31:0] inst, input logic [31:0] pc);
    check({tag, "_valid"}, 32'(id_valid), 32'd1);
    check({tag, "_inst"}, id_inst, inst);
    check({tag, "_pc"}, 32'(id_pc), pc);
  endtask

  logic [31:0] exp_fetched;
  logic [31:0] exp_stall;

  initial begin
`ifdef FETCH_PERF_CNT_EN
    exp_fetched = 32'd10;
    exp_stall   = 32'd4;
`else
    exp_fetched = 32'd0;
    exp_stall   = 32'd0;
`endif
    rst = 1'b0; stall = 1'b0; redirect_en = 1'b0; redirect_pc = '0;
    tick(); tick();
    check("rst_valid", 32'(id_valid), 32'd0);
    check("rst_inst", id_inst, 32'h0);
    check("rst_pc", 32'(id_pc), 32'h0);
    check("rst_en", 32'(imem_en), 32'd0);
    check("rst_perf_f", perf_fetched, 32'd0);
    check("rst_perf_s", perf_stall, 32'd0);

    // Reset release: addresses 0,1,2 and first instruction two edges later
    rst = 1'b1; #1;
    check("boot_addr", 32'(imem_addr), 32'h0);
    check("boot_en", 32'(imem_en), 32'd1);
    tick();
    check("e1_valid", 32'(id_valid), 32'd0);
    check("e1_addr", 32'(imem_addr), 32'h1);
    tick();
    check_id("e2", 32'h100, 32'h0);
    check("e2_addr", 32'(imem_addr), 32'h2);
    tick(); check_id("e3", 32'h101, 32'h1);
    tick(); check_id("e4", 32'h102, 32'h2);
    tick(); tick(); tick();
    check_id("e7", 32'h105, 32'h5);

    // Stall for three edges while 0x105 sits in IF/ID
    stall = 1'b1; #1;
    check("stall_en", 32'(imem_en), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_id("stall_hold", 32'h105, 32'h5);
    end
    stall = 1'b0;
    tick(); check_id("rel0", 32'h106, 32'h6);
    tick(); check_id("rel1", 32'h107, 32'h7);
    tick(); check_id("rel2", 32'h108, 32'h8);
    tick(); check_id("rel3", 32'h109, 32'h9);

    // One more stall edge: 10 fetches and 4 stall cycles since reset
    stall = 1'b1;
    tick();
    check_id("perf_hold", 32'h109, 32'h9);
    check("perf_fetched", perf_fetched, exp_fetched);
    check("perf_stall", perf_stall, exp_stall);

    // Redirect while stalled takes priority
    redirect_en = 1'b1; redirect_pc = 9'h040; #1;
    check("redir_addr", 32'(imem_addr), 32'h40);
    check("redir_en", 32'(imem_en), 32'd1);
    tick();
    redirect_en = 1'b0; stall = 1'b0;
    check("redir_bubble", 32'(id_valid), 32'd0);
    check("redir_nop", id_inst, 32'h0);
    tick(); check_id("redir_tgt", 32'h140, 32'h40);
    tick(); check_id("redir_next", 32'h141, 32'h41);

    // PC wrap from the all-ones address
    redirect_en = 1'b1; redirect_pc = 9'h1FE;
    tick();
    redirect_en = 1'b0;
    tick(); check_id("wrap0", 32'h2FE, 32'h1FE);
    tick(); check_id("wrap1", 32'h2FF, 32'h1FF);
    tick(); check_id("wrap2", 32'h100, 32'h000);

    // Reset while HOLD with the skid full
    stall = 1'b1;
    tick();
    check("skid_full", 32'(dut.skid_full), 32'd1);
    tick();
    rst = 1'b0; #1;
    check("rst_hold_en", 32'(imem_en), 32'd0);
    tick();
    check("rst2_valid", 32'(id_valid), 32'd0);
    check("rst2_skid", 32'(dut.skid_full), 32'd0);
    check("rst2_perf_f", perf_fetched, 32'd0);
    rst = 1'b1; stall = 1'b0; #1;
    check("rst2_addr", 32'(imem_addr), 32'h0);
    check("rst2_en", 32'(imem_en), 32'd1);
    tick();
    check("rst2_e1_valid", 32'(id_valid), 32'd0);
    tick(); check_id("rst2_e2", 32'h100, 32'h0);
    tick(); check_id("rst2_e3", 32'h101, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
